// File: rtl/seg_decode_rx.sv
// rtl/seg_decode_rx.sv - seven-segment pattern receiver: stability filter, hex decode, error count, output FIFO
module seg_decode_rx #(
    parameter int STABLE_CYCLES = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       seg_in,
    input  logic             seg_valid,
    output logic [3:0]       hex_out,
    output logic             dp_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             bad_pattern,
    output logic [ERR_W-1:0] err_count,
    output logic             overflow
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [7:0] LAST_CNT = 8'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_HELD  = 2'd2
    } state_t;

    state_t           state_q;
    logic [7:0]       cand_q;
    logic [7:0]       cnt_q;
    logic             bad_q;
    logic [ERR_W-1:0] err_q;

    logic             dec_legal;
    logic             dec_blank;
    logic [3:0]       dec_val;
    logic             accept_w;
    logic             push_w;
    logic             acc_illegal;

    logic [4:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [4:0]       last_q;
    logic             ovf_q;
    logic             empty_w;
    logic             full_w;
    logic             pop_w;
    logic             push_ok;

    // Map the candidate's g..a bits back to a hex digit; blank and illegal are told apart
    always_comb begin
        dec_legal = 1'b1;
        dec_blank = 1'b0;
        dec_val   = 4'h0;
        case (cand_q[6:0])
            7'h3F: dec_val = 4'h0;
            7'h06: dec_val = 4'h1;
            7'h5B: dec_val = 4'h2;
            7'h4F: dec_val = 4'h3;
            7'h66: dec_val = 4'h4;
            7'h6D: dec_val = 4'h5;
            7'h7D: dec_val = 4'h6;
            7'h07: dec_val = 4'h7;
            7'h7F: dec_val = 4'h8;
            7'h6F: dec_val = 4'h9;
            7'h77: dec_val = 4'hA;
            7'h7C: dec_val = 4'hB;
            7'h39: dec_val = 4'hC;
            7'h5E: dec_val = 4'hD;
            7'h79: dec_val = 4'hE;
            7'h71: dec_val = 4'hF;
            7'h00: begin
                dec_legal = 1'b0;
                dec_blank = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Acceptance happens on the edge of the last matching sample; the candidate equals seg_in then
    assign accept_w    = (state_q == S_COUNT) && seg_valid && (seg_in == cand_q) && (cnt_q == LAST_CNT);
    assign push_w      = accept_w && dec_legal;
    assign acc_illegal = accept_w && !dec_legal && !dec_blank;

    // Stability filter FSM with registered illegal-pattern pulse and saturating error counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cand_q  <= 8'h00;
            cnt_q   <= 8'h00;
            bad_q   <= 1'b0;
            err_q   <= '0;
        end else begin
            bad_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (seg_valid) begin
                        cand_q  <= seg_in;
                        cnt_q   <= 8'd1;
                        state_q <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (!seg_valid) begin
                        state_q <= S_IDLE;
                    end else if (seg_in != cand_q) begin
                        cand_q <= seg_in;
                        cnt_q  <= 8'd1;
                    end else if (cnt_q == LAST_CNT) begin
                        state_q <= S_HELD;
                        if (acc_illegal) begin
                            bad_q <= 1'b1;
                            if (err_q != {ERR_W{1'b1}}) begin
                                err_q <= err_q + 1'b1;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_HELD: begin
                    if (!seg_valid) begin
                        state_q <= S_IDLE;
                    end else if (seg_in != cand_q) begin
                        cand_q  <= seg_in;
                        cnt_q   <= 8'd1;
                        state_q <= S_COUNT;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == DEPTH_C);
    assign pop_w   = !empty_w && out_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle
    assign push_ok = push_w && (!full_w || pop_w);

    // Next occupancy from the push/pop pair
    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_w) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop_w) begin
            count_d = count_q - CW'(1);
        end
    end

    // Storage array; contents are don't-care while the slot is unoccupied
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[wr_ptr_q] <= {seg_in[7], dec_val};
        end
    end

    // FIFO pointers, occupancy, held-output copy and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= 5'h00;
            ovf_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_w) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                last_q   <= mem_q[rd_ptr_q];
            end
            if (push_w && !push_ok) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign out_valid   = !empty_w;
    assign hex_out     = empty_w ? last_q[3:0] : mem_q[rd_ptr_q][3:0];
    assign dp_out      = empty_w ? last_q[4]   : mem_q[rd_ptr_q][4];
    assign bad_pattern = bad_q;
    assign err_count   = err_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_seg_decode_rx.sv
// tb/tb_seg_decode_rx.sv - randomized and directed bench for seg_decode_rx against a run-length reference model
module tb_seg_decode_rx;

    localparam int SC = 4;
    localparam int FD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] seg_in;
    logic       seg_valid;
    logic       out_ready;
    logic [3:0] hex_out, hex2;
    logic       dp_out, dp2;
    logic       out_valid, valid2;
    logic       bad_pattern, bad2;
    logic [7:0] err_count;
    logic [1:0] err2;
    logic       overflow, ovf2;

    always #5 clk = ~clk;

    seg_decode_rx #(.STABLE_CYCLES(SC), .FIFO_DEPTH(FD), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .seg_valid(seg_valid),
        .hex_out(hex_out), .dp_out(dp_out), .out_valid(out_valid), .out_ready(out_ready),
        .bad_pattern(bad_pattern), .err_count(err_count), .overflow(overflow)
    );

    seg_decode_rx #(.STABLE_CYCLES(SC), .FIFO_DEPTH(FD), .ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .seg_in(seg_in), .seg_valid(seg_valid),
        .hex_out(hex2), .dp_out(dp2), .out_valid(valid2), .out_ready(out_ready),
        .bad_pattern(bad2), .err_count(err2), .overflow(ovf2)
    );

    int total = 0;
    int bad   = 0;

    logic [6:0] pat_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // reference model: FIFO as a queue, stability as a run length of identical valid samples
    logic [4:0] mq [$];
    logic [4:0] m_last;
    int         m_err, m_err2;
    logic       m_bad, m_ovf;
    logic [7:0] run_prev;
    int         run_len;

    function automatic int lookup(input logic [6:0] p);
        for (int i = 0; i < 16; i++) if (pat_tab[i] == p) return i;
        return -1;
    endfunction

    function automatic logic [4:0] exp_head();
        return (mq.size() > 0) ? mq[0] : m_last;
    endfunction

    task automatic cyc(input logic r, input logic [7:0] s, input logic v, input logic rdy);
        int idx;
        rst = r; seg_in = s; seg_valid = v; out_ready = rdy;
        @(posedge clk);
        if (r) begin
            mq.delete(); m_last = 5'h00; m_err = 0; m_err2 = 0;
            m_bad = 1'b0; m_ovf = 1'b0; run_len = 0; run_prev = 8'h00;
        end else begin
            if (mq.size() > 0 && rdy) m_last = mq.pop_front();
            m_bad = 1'b0;
            if (!v) run_len = 0;
            else if (run_len > 0 && s == run_prev) begin
                if (run_len <= SC) run_len++;
            end else run_len = 1;
            run_prev = s;
            if (v && run_len == SC && s[6:0] != 7'h00) begin
                idx = lookup(s[6:0]);
                if (idx < 0) begin
                    m_bad = 1'b1;
                    if (m_err < 255) m_err++;
                    if (m_err2 < 3) m_err2++;
                end else if (mq.size() < FD) mq.push_back({s[7], 4'(idx)});
                else m_ovf = 1'b1;
            end
        end
        #1;
    endtask

    task automatic hold(input logic [7:0] s, input int n, input logic rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, s, 1'b1, rdy);
    endtask

    task automatic test_reset();
        cyc(1'b1, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 8'h00, 1'b0, 1'b0);
        total++;
        if ({out_valid, hex_out, dp_out, bad_pattern, overflow} !== 8'h00) begin
            bad++; $display("FAIL reset_outputs: got %b want 00000000", {out_valid, hex_out, dp_out, bad_pattern, overflow});
        end
        total++;
        if (err_count !== 8'd0) begin bad++; $display("FAIL reset_err: got %0d want 0", err_count); end
    endtask

    task automatic test_single();
        int extra;
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        hold(8'h5B, 3, 1'b1);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early: out_valid=%b want 0", out_valid); end
        hold(8'h5B, 1, 1'b1);
        total++;
        if ({out_valid, hex_out, dp_out} !== {1'b1, 4'h2, 1'b0}) begin
            bad++; $display("FAIL single_data: got v=%b hex=%h dp=%b want v=1 hex=2 dp=0", out_valid, hex_out, dp_out);
        end
        extra = 0;
        for (int i = 0; i < 16; i++) begin
            hold(8'h5B, 1, 1'b1);
            if (out_valid) extra++;
        end
        total++;
        if (extra != 0) begin bad++; $display("FAIL single_no_repeat: extra entries=%0d want 0", extra); end
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_dp_restart();
        hold(8'hF9, 4, 1'b0);
        total++;
        if ({out_valid, hex_out, dp_out} !== {1'b1, 4'hE, 1'b1}) begin
            bad++; $display("FAIL dp_data: got v=%b hex=%h dp=%b want v=1 hex=e dp=1", out_valid, hex_out, dp_out);
        end
        hold(8'h7F, 3, 1'b0);
        hold(8'h06, 4, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        total++;
        if ({out_valid, hex_out, dp_out} !== {1'b1, 4'h1, 1'b0}) begin
            bad++; $display("FAIL restart_second: got v=%b hex=%h dp=%b want v=1 hex=1 dp=0", out_valid, hex_out, dp_out);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        total++;
        if ({out_valid, hex_out} !== {1'b0, 4'h1}) begin
            bad++; $display("FAIL restart_empty_hold: got v=%b hex=%h want v=0 hex=1", out_valid, hex_out);
        end
    endtask

    task automatic test_illegal();
        int pulses, seen_valid;
        cyc(1'b1, 8'h00, 1'b0, 1'b1);
        pulses = 0; seen_valid = 0;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 5; i++) begin
                cyc(1'b0, 8'h55, (i < 4), 1'b1);
                if (bad_pattern) pulses++;
                if (out_valid) seen_valid++;
            end
        end
        total++;
        if (pulses != 3) begin bad++; $display("FAIL illegal_pulses: got %0d want 3", pulses); end
        total++;
        if (err_count !== 8'd3) begin bad++; $display("FAIL illegal_count: got %0d want 3", err_count); end
        total++;
        if (seen_valid != 0) begin bad++; $display("FAIL illegal_no_push: valid cycles=%0d want 0", seen_valid); end
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 8'h00, (i < 4), 1'b1);
            if (bad_pattern) pulses++;
            if (out_valid) seen_valid++;
        end
        total++;
        if (pulses != 0 || seen_valid != 0 || err_count !== 8'd3) begin
            bad++; $display("FAIL blank: pulses=%0d valid=%0d err=%0d want 0 0 3", pulses, seen_valid, err_count);
        end
    endtask

    task automatic test_overflow();
        cyc(1'b1, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            hold({1'b0, pat_tab[k]}, 4, 1'b0);
            cyc(1'b0, 8'h00, 1'b0, 1'b0);
        end
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL overflow_set: got %b want 1", overflow); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({out_valid, hex_out} !== {1'b1, 4'(i)}) begin
                bad++; $display("FAIL overflow_drain%0d: got v=%b hex=%h want v=1 hex=%0h", i, out_valid, hex_out, i);
            end
            cyc(1'b0, 8'h00, 1'b0, 1'b1);
        end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL overflow_empty: out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_full_pop();
        cyc(1'b1, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            hold({1'b0, pat_tab[k]}, 4, 1'b0);
            cyc(1'b0, 8'h00, 1'b0, 1'b0);
        end
        hold(8'h66, 3, 1'b0);
        hold(8'h66, 1, 1'b1);
        total++;
        if ({overflow, out_valid, hex_out} !== {1'b0, 1'b1, 4'h1}) begin
            bad++; $display("FAIL fullpop_accept: got ovf=%b v=%b hex=%h want ovf=0 v=1 hex=1", overflow, out_valid, hex_out);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 1; i < 5; i++) begin
            total++;
            if ({out_valid, hex_out} !== {1'b1, 4'(i)}) begin
                bad++; $display("FAIL fullpop_order%0d: got v=%b hex=%h want v=1 hex=%0h", i, out_valid, hex_out, i);
            end
            cyc(1'b0, 8'h00, 1'b0, 1'b1);
        end
        total++;
        if (out_valid !== 1'b0 || overflow !== 1'b0) begin
            bad++; $display("FAIL fullpop_end: got v=%b ovf=%b want 0 0", out_valid, overflow);
        end
    endtask

    task automatic test_reset_mid();
        cyc(1'b1, 8'h00, 1'b0, 1'b0);
        hold(8'h5B, 2, 1'b0);
        cyc(1'b1, 8'h5B, 1'b1, 1'b0);
        hold(8'h5B, 3, 1'b0);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_restart_early: out_valid=%b want 0", out_valid); end
        hold(8'h5B, 1, 1'b0);
        total++;
        if ({out_valid, hex_out} !== {1'b1, 4'h2}) begin
            bad++; $display("FAIL midrst_restart: got v=%b hex=%h want v=1 hex=2", out_valid, hex_out);
        end
        hold(8'h06, 4, 1'b0);
        hold(8'h55, 4, 1'b0);
        cyc(1'b1, 8'h00, 1'b0, 1'b0);
        total++;
        if ({out_valid, hex_out, dp_out, err_count} !== 14'h0) begin
            bad++; $display("FAIL midrst_clear: got v=%b hex=%h dp=%b err=%0d want all 0", out_valid, hex_out, dp_out, err_count);
        end
        for (int k = 0; k < 5; k++) begin
            hold(8'hD5, 4, 1'b1);
            cyc(1'b0, 8'h00, 1'b0, 1'b1);
        end
        total++;
        if (err2 !== 2'd3 || err_count !== 8'd5) begin
            bad++; $display("FAIL err_saturate: got err2=%0d err=%0d want 3 5", err2, err_count);
        end
    endtask

    task automatic test_random();
        logic [7:0] s;
        logic       v, r, rdy;
        int         len, kind;
        logic [4:0] eh;
        cyc(1'b1, 8'h00, 1'b0, 1'b0);
        for (int n = 0; n < 120; n++) begin
            kind = $urandom_range(0, 7);
            len  = $urandom_range(1, 7);
            v    = 1'b1;
            if (kind <= 4) s = {1'($urandom), pat_tab[$urandom_range(0, 15)]};
            else if (kind == 5) begin
                s = {1'($urandom), 7'($urandom)};
                while (s[6:0] == 7'h00 || lookup(s[6:0]) >= 0) s = {1'($urandom), 7'($urandom)};
            end else if (kind == 6) s = {1'($urandom), 7'h00};
            else begin s = 8'($urandom); v = 1'b0; end
            for (int i = 0; i < len; i++) begin
                r   = ($urandom_range(0, 199) == 0);
                rdy = ($urandom_range(0, 2) != 0);
                cyc(r, s, v, rdy);
                eh = exp_head();
                total++;
                if ({out_valid, dp_out, hex_out, bad_pattern, overflow, err_count, err2} !==
                    {(mq.size() > 0), eh[4], eh[3:0], m_bad, m_ovf, 8'(m_err), 2'(m_err2)}) begin
                    bad++;
                    $display("FAIL random n=%0d: got v=%b dp=%b hex=%h bad=%b ovf=%b err=%0d err2=%0d want v=%b dp=%b hex=%h bad=%b ovf=%b err=%0d err2=%0d",
                             n, out_valid, dp_out, hex_out, bad_pattern, overflow, err_count, err2,
                             (mq.size() > 0), eh[4], eh[3:0], m_bad, m_ovf, m_err, m_err2);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; seg_in = 8'h00; seg_valid = 1'b0; out_ready = 1'b0;
        test_reset();
        test_single();
        test_dp_restart();
        test_illegal();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
